// File: rtl/regn_univ.sv
// -----------------------------------------------------------------------------
// regn_univ -- parametrised universal datapath register
//
// A WIDTH-bit register with a programmable reset value and eight operations
// selected by MODE: hold, load, shift left/right (through Ser_In), increment,
// decrement, rotate left/right. Reports the bit last shifted or rotated out
// (Ser_Out), an inc/dec carry/borrow flag (Carry) and a combinational
// all-zero flag (Zero).
//
// Parameters
//   WIDTH      register width in bits (>= 2)
//   RESET_VAL  value Reg_Out takes on reset
//
// Ports
//   clk      in   rising-edge clock, sole clock domain
//   res      in   synchronous active-high reset (priority over EN/MODE)
//   EN       in   operation enable; 0 holds all state
//   MODE     in   3-bit operation select
//   Reg_In   in   parallel load data
//   Ser_In   in   serial input bit used by the shifts
//   Reg_Out  out  registered register contents
//   Ser_Out  out  registered bit last shifted/rotated out
//   Carry    out  registered carry (inc) / borrow (dec) flag
//   Zero     out  combinational, 1 when Reg_Out == 0
//
// Configuration macro: REGN_UNIV_ROTATE_EN
//   defined   -> MODE 110/111 rotate left/right
//   undefined -> MODE 110/111 behave as hold; no rotate logic is built
// -----------------------------------------------------------------------------
module regn_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] Reg_In,
  input  logic             Ser_In,
  output logic [WIDTH-1:0] Reg_Out,
  output logic             Ser_Out,
  output logic             Carry,
  output logic             Zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_INC  = 3'b100,
    MODE_DEC  = 3'b101,
    MODE_ROL  = 3'b110,
    MODE_ROR  = 3'b111
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(MODE);

  // The extra MSB of the increment sum is the carry out of the all-ones wrap.
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] dec_val;

  assign inc_sum = {1'b0, Reg_Out} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_val = Reg_Out - {{(WIDTH-1){1'b0}}, 1'b1};

  // NOTE: state is updated with non-blocking assignments so every operation
  // reads the pre-edge Reg_Out, independent of statement order.
  always_ff @(posedge clk) begin
    if (res) begin
      Reg_Out <= RESET_VAL;
      Ser_Out <= 1'b0;
      Carry   <= 1'b0;
    end else if (EN) begin
      // Carry is a one-operation flag: every enabled mode clears it unless
      // the inc/dec branch below overrides it.
      Carry <= 1'b0;
      case (mode)
        MODE_HOLD: ;
        MODE_LOAD: Reg_Out <= Reg_In;
        MODE_SHL: begin
          Reg_Out <= {Reg_Out[WIDTH-2:0], Ser_In};
          Ser_Out <= Reg_Out[WIDTH-1];
        end
        MODE_SHR: begin
          Reg_Out <= {Ser_In, Reg_Out[WIDTH-1:1]};
          Ser_Out <= Reg_Out[0];
        end
        MODE_INC: begin
          Reg_Out <= inc_sum[WIDTH-1:0];
          Carry   <= inc_sum[WIDTH];
        end
        MODE_DEC: begin
          Reg_Out <= dec_val;
          Carry   <= (Reg_Out == {WIDTH{1'b0}});  // borrow only on 0 -> all-ones
        end
`ifdef REGN_UNIV_ROTATE_EN
        MODE_ROL: begin
          Reg_Out <= {Reg_Out[WIDTH-2:0], Reg_Out[WIDTH-1]};
          Ser_Out <= Reg_Out[WIDTH-1];
        end
        MODE_ROR: begin
          Reg_Out <= {Reg_Out[0], Reg_Out[WIDTH-1:1]};
          Ser_Out <= Reg_Out[0];
        end
`else
        // Without the rotate option these codes are plain holds.
        MODE_ROL, MODE_ROR: ;
`endif
        default: ;
      endcase
    end
  end

  assign Zero = ~|Reg_Out;

endmodule

// File: tb/tb_regn_univ.sv
// -----------------------------------------------------------------------------
// tb_regn_univ -- self-checking bench for regn_univ
//
// Three instances (8-bit with RESET_VAL 8'hA5, 4-bit with RESET_VAL 4'h6,
// 16-bit with RESET_VAL 0) receive the same stimulus each cycle; a small
// arithmetic reference model predicts Reg_Out/Ser_Out/Carry/Zero for each.
// Directed steps follow the documented scenarios, then randomized cycles.
// -----------------------------------------------------------------------------
module tb_regn_univ;

  logic        clk = 1'b0;
  logic        res;
  logic        en;
  logic [2:0]  mode;
  logic [15:0] din;
  logic        sin;

  logic [7:0]  q8;
  logic        so8, c8, z8;
  logic [3:0]  q4;
  logic        so4, c4, z4;
  logic [15:0] q16;
  logic        so16, c16, z16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regn_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) u_w8 (
    .clk(clk), .res(res), .EN(en), .MODE(mode), .Reg_In(din[7:0]),
    .Ser_In(sin), .Reg_Out(q8), .Ser_Out(so8), .Carry(c8), .Zero(z8)
  );

  regn_univ #(.WIDTH(4), .RESET_VAL(4'h6)) u_w4 (
    .clk(clk), .res(res), .EN(en), .MODE(mode), .Reg_In(din[3:0]),
    .Ser_In(sin), .Reg_Out(q4), .Ser_Out(so4), .Carry(c4), .Zero(z4)
  );

  regn_univ #(.WIDTH(16), .RESET_VAL(16'h0000)) u_w16 (
    .clk(clk), .res(res), .EN(en), .MODE(mode), .Reg_In(din),
    .Ser_In(sin), .Reg_Out(q16), .Ser_Out(so16), .Carry(c16), .Zero(z16)
  );

`ifdef REGN_UNIV_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  // Reference model: register value as a plain number modulo 2**w.
  typedef struct {
    longint q;
    bit     so;
    bit     c;
  } st_t;

  st_t m8, m4, m16;

  function automatic st_t model_next(int w, longint rv, st_t s, bit r, bit e,
                                     int md, longint d, bit si);
    st_t    n;
    longint m;
    longint top;
    longint low;
    m   = longint'(1) << w;
    n   = s;
    top = (s.q >> (w - 1)) & 1;
    low = s.q % 2;
    if (r) begin
      n.q  = rv;
      n.so = 1'b0;
      n.c  = 1'b0;
    end else if (e) begin
      n.c = 1'b0;
      case (md)
        1: n.q = d % m;
        2: begin n.so = top[0]; n.q = (s.q * 2 + longint'(si)) % m; end
        3: begin n.so = low[0]; n.q = s.q / 2 + longint'(si) * (m / 2); end
        4: begin n.c = (s.q + 1 == m); n.q = (s.q + 1) % m; end
        5: begin n.c = (s.q == 0); n.q = (s.q + m - 1) % m; end
        6: if (ROT_EN) begin n.so = top[0]; n.q = (s.q * 2) % m + top; end
        7: if (ROT_EN) begin n.so = low[0]; n.q = s.q / 2 + low * (m / 2); end
        default: ;
      endcase
    end
    return n;
  endfunction

  task automatic check(string tag, longint obs, longint exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, sample #1 after the edge, compare.
  task automatic step(bit r, bit e, int md, longint d, bit si);
    res  = r;
    en   = e;
    mode = 3'(md);
    din  = d[15:0];
    sin  = si;
    @(posedge clk);
    #1;
    m8  = model_next(8,  'hA5, m8,  r, e, md, d[7:0], si);
    m4  = model_next(4,  'h6,  m4,  r, e, md, d[3:0], si);
    m16 = model_next(16, 'h0,  m16, r, e, md, d[15:0], si);
    check("w8_q",     64'(q8),   m8.q);
    check("w8_ser",   64'(so8),  64'(m8.so));
    check("w8_carry", 64'(c8),   64'(m8.c));
    check("w8_zero",  64'(z8),   64'(m8.q == 0));
    check("w4_q",     64'(q4),   m4.q);
    check("w4_ser",   64'(so4),  64'(m4.so));
    check("w4_carry", 64'(c4),   64'(m4.c));
    check("w4_zero",  64'(z4),   64'(m4.q == 0));
    check("w16_q",    64'(q16),  m16.q);
    check("w16_ser",  64'(so16), 64'(m16.so));
    check("w16_carry",64'(c16),  64'(m16.c));
    check("w16_zero", 64'(z16),  64'(m16.q == 0));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b1; en = 1'b0; mode = 3'd0; din = 16'h0; sin = 1'b0;
    m8 = '{0, 0, 0}; m4 = '{0, 0, 0}; m16 = '{0, 0, 0};

    // Reset has priority over an enabled load of all-ones.
    step(1, 1, 1, 'hFFFF, 0);
    check("plan_reset_q",    64'(q8), 'hA5);
    check("plan_reset_zero", 64'(z8), 0);
    check("plan_reset16_z",  64'(z16), 1);

    // Load then hold with EN=0 while MODE says increment.
    step(0, 1, 1, 'h3C, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 4, 'h0, 1);
    check("plan_hold_q", 64'(q8), 'h3C);

    // Shift left then right.
    step(0, 1, 1, 'h81, 0);
    step(0, 1, 2, 'h0, 0);
    check("plan_shl_q",   64'(q8),  'h02);
    check("plan_shl_ser", 64'(so8), 1);
    step(0, 1, 3, 'h0, 1);
    check("plan_shr_q",   64'(q8),  'h81);
    check("plan_shr_ser", 64'(so8), 0);

    // Count wrap both ways; carry holds through EN=0.
    step(0, 1, 1, 'hFFFF, 0);
    step(0, 1, 4, 'h0, 0);
    check("plan_inc_wrap_q", 64'(q8), 'h00);
    check("plan_inc_carry",  64'(c8), 1);
    check("plan_inc_zero",   64'(z8), 1);
    step(0, 0, 1, 'h55, 0);
    check("plan_carry_hold", 64'(c8), 1);
    step(0, 1, 5, 'h0, 0);
    check("plan_dec_wrap_q", 64'(q8), 'hFF);
    check("plan_dec_borrow", 64'(c8), 1);
    step(0, 1, 5, 'h0, 0);
    check("plan_dec_q",      64'(q8), 'hFE);
    check("plan_dec_nocarry",64'(c8), 0);

    // Rotate left, then right.
    step(0, 1, 1, 'h81, 0);
    step(0, 1, 6, 'h0, 0);
`ifdef REGN_UNIV_ROTATE_EN
    check("plan_rol_q",   64'(q8),  'h03);
    check("plan_rol_ser", 64'(so8), 1);
`else
    check("plan_rol_q",   64'(q8),  'h81);
    check("plan_rol_ser", 64'(so8), 0);
`endif
    step(0, 1, 7, 'h0, 1);

    // Reset on the wrap cycle of a count discards the increment.
    step(0, 1, 1, 'hFFFF, 0);
    step(1, 1, 4, 'h0, 0);
    check("plan_w4_reset_q",     64'(q4), 'h6);
    check("plan_w4_reset_carry", 64'(c4), 0);

    // 16-bit increment wrap.
    step(0, 1, 1, 'hFFFF, 0);
    step(0, 1, 4, 'h0, 0);
    check("plan_w16_wrap_q",     64'(q16), 'h0000);
    check("plan_w16_wrap_carry", 64'(c16), 1);

    // Randomized operations, occasional reset and disabled cycles.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), longint'($urandom),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
